// File: rtl/ctu_test_scan_seq_if.sv
// rtl/ctu_test_scan_seq_if.sv - request/response and scan-stub signal bundle for ctu_test_scan_seq
//
// Purpose
//   Groups the scan request handshake, the result signals and the chain
//   stub connections of ctu_test_scan_seq into one interface. The clock
//   (jbus_clk) and reset (jbus_rst_l) are not part of the bundle.
//
// Signals
//   scan_start           1   one-cycle request to run one scan operation
//   scan_short_chain     1   chain select sampled with scan_start (1 = short)
//   scan_len             6   shift count sampled with scan_start (1..32, 0 invalid)
//   scan_wdata           32  load pattern sampled with scan_start, LSB first
//   scan_abort           1   terminate the current operation
//   scan_so_0            1   chain scan-out returned by the stub
//   global_shift_enable  1   shift enable to the stub
//   ctu_tst_short_chain  1   latched chain select to the stub
//   scan_si              1   serial scan-in data
//   scan_busy            1   operation in progress
//   scan_done            1   one-cycle completion pulse
//   scan_err             1   one-cycle pulse on a rejected request
//   scan_rdata           32  captured scan-out bits
//   scan_rparity         1   parity of scan_rdata (0 when parity is not built)
//
// Modports
//   master : requester / chain stub side (drives requests and scan_so_0)
//   slave  : the sequencer itself

interface ctu_test_scan_seq_if;

  logic        scan_start;
  logic        scan_short_chain;
  logic [5:0]  scan_len;
  logic [31:0] scan_wdata;
  logic        scan_abort;
  logic        scan_so_0;

  logic        global_shift_enable;
  logic        ctu_tst_short_chain;
  logic        scan_si;
  logic        scan_busy;
  logic        scan_done;
  logic        scan_err;
  logic [31:0] scan_rdata;
  logic        scan_rparity;

  modport master (
    output scan_start,
    output scan_short_chain,
    output scan_len,
    output scan_wdata,
    output scan_abort,
    output scan_so_0,
    input  global_shift_enable,
    input  ctu_tst_short_chain,
    input  scan_si,
    input  scan_busy,
    input  scan_done,
    input  scan_err,
    input  scan_rdata,
    input  scan_rparity
  );

  modport slave (
    input  scan_start,
    input  scan_short_chain,
    input  scan_len,
    input  scan_wdata,
    input  scan_abort,
    input  scan_so_0,
    output global_shift_enable,
    output ctu_tst_short_chain,
    output scan_si,
    output scan_busy,
    output scan_done,
    output scan_err,
    output scan_rdata,
    output scan_rparity
  );

endinterface

// File: rtl/ctu_test_scan_seq.sv
// rtl/ctu_test_scan_seq.sv - scan chain shift sequencer (load pattern out, capture scan-out in)
//
// Purpose
//   Accepts a one-cycle scan request, shifts the latched pattern into the
//   selected chain LSB first for scan_len cycles while capturing the chain's
//   scan-out into scan_rdata, then pulses scan_done. Zero-length requests
//   are rejected with a scan_err pulse; scan_abort ends a shift early.
//
// Ports
//   jbus_clk    in   sole clock, rising edge
//   jbus_rst_l  in   asynchronous active-low reset
//   bus         slave modport of ctu_test_scan_seq_if (requests, results,
//               and the chain stub connections)
//
// Configuration
//   CTU_SCAN_PARITY_EN : when defined, scan_rparity holds the XOR of the
//   completed scan_rdata from DONE until the next accepted start. When not
//   defined, scan_rparity is tied to 0 and no parity flop exists.
//
// All outputs come straight from flops or from decodes of the state
// register; no input reaches an output combinationally.

module ctu_test_scan_seq (
  input  logic                 jbus_clk,
  input  logic                 jbus_rst_l,
  ctu_test_scan_seq_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  // Remaining shifts; loaded with scan_len on acceptance.
  logic [5:0]  cnt_q, cnt_d;
  // Bit position of the current shift cycle within scan_rdata.
  logic [4:0]  idx_q, idx_d;
  // Pattern shifts right every cycle so bit 0 is always the next scan-in bit.
  logic [31:0] pat_q, pat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        short_q, short_d;
  logic        err_q, err_d;

  logic        in_shift;
  logic        accept;

  assign in_shift = (state_q == ST_SHIFT);
  assign accept   = (state_q == ST_IDLE) && bus.scan_start && (bus.scan_len != 6'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    rdata_d = rdata_q;
    short_d = short_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.scan_start) begin
          if (bus.scan_len != 6'd0) begin
            state_d = ST_SHIFT;
            cnt_d   = bus.scan_len;
            idx_d   = 5'd0;
            pat_d   = bus.scan_wdata;
            rdata_d = 32'd0;
            short_d = bus.scan_short_chain;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        // The closing edge of every shift cycle captures scan-out, including
        // an aborted one, so an abort keeps all bits shifted so far.
        rdata_d[idx_q] = bus.scan_so_0;
        pat_d          = {1'b0, pat_q[31:1]};
        idx_d          = idx_q + 5'd1;
        if (bus.scan_abort) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end else if (cnt_q == 6'd1) begin
          state_d = ST_DONE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge jbus_clk or negedge jbus_rst_l) begin
    if (!jbus_rst_l) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      idx_q   <= 5'd0;
      pat_q   <= 32'd0;
      rdata_q <= 32'd0;
      short_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      rdata_q <= rdata_d;
      short_q <= short_d;
      err_q   <= err_d;
    end
  end

`ifdef CTU_SCAN_PARITY_EN
  logic par_q, par_d;
  logic finishing;

  // Parity is taken from the final captured word on the edge entering DONE,
  // so it is valid in the same cycle as scan_done.
  assign finishing = in_shift && !bus.scan_abort && (cnt_q == 6'd1);

  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = 1'b0;
    end else if (finishing) begin
      par_d = ^rdata_d;
    end
  end

  always_ff @(posedge jbus_clk or negedge jbus_rst_l) begin
    if (!jbus_rst_l) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.scan_rparity = par_q;
`else
  logic unused_accept;
  assign unused_accept    = accept;
  assign bus.scan_rparity = 1'b0;
`endif

  assign bus.global_shift_enable = in_shift;
  assign bus.scan_busy           = in_shift;
  assign bus.scan_done           = (state_q == ST_DONE);
  assign bus.scan_err            = err_q;
  assign bus.scan_si             = in_shift & pat_q[0];
  assign bus.ctu_tst_short_chain = short_q;
  assign bus.scan_rdata          = rdata_q;

endmodule

// File: doc/ctu_test_scan_seq.md
CTU_TEST_SCAN_SEQ -- requirements
Module: ctu_test_scan_seq

Interface
REQ-001 The block SHALL have exactly one clock and one reset, as listed in REQ-002 and REQ-003.
REQ-002 jbus_clk  input  1  sole clock; all flops rising-edge.
REQ-003 jbus_rst_l  input  1  reset, asynchronous assert, active-low.
REQ-004 scan_start  input  1  one-cycle request to run one scan operation.
REQ-005 scan_short_chain  input  1  chain select, sampled with scan_start (1 = short chain, 0 = long chain).
REQ-006 scan_len  input  6  shift count, sampled with scan_start; 1..32 valid, 0 invalid.
REQ-007 scan_wdata  input  32  load pattern, sampled with scan_start, shifted out LSB first.
REQ-008 scan_abort  input  1  terminate the current operation.
REQ-009 scan_so_0  input  1  returned chain scan-out (stub so_0).
REQ-010 global_shift_enable  output  1  shift enable to the stub.
REQ-011 ctu_tst_short_chain  output  1  latched chain select to the stub.
REQ-012 scan_si  output  1  serial scan-in data.
REQ-013 scan_busy  output  1  operation in progress.
REQ-014 scan_done  output  1  one-cycle completion pulse.
REQ-015 scan_err  output  1  one-cycle pulse on a rejected request.
REQ-016 scan_rdata  output  32  captured scan-out bits.
REQ-017 scan_rparity  output  1  parity of scan_rdata (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-019 In IDLE, scan_start=1 with scan_len!=0 SHALL latch len, chain select and pattern, clear scan_rdata, and enter SHIFT on the next edge.
REQ-020 In IDLE, scan_start=1 with scan_len=0 SHALL pulse scan_err for one cycle, remain in IDLE, and leave scan_rdata unchanged.
REQ-021 scan_start SHALL be ignored outside IDLE (no error, no effect).
REQ-022 In SHIFT, global_shift_enable=1 and scan_busy=1 for exactly len cycles; both SHALL be 0 in all other states.
REQ-023 In shift cycle i (0-based), scan_si SHALL equal pattern bit i, and scan_so_0 SHALL be sampled at the closing edge into scan_rdata[i].
REQ-024 scan_rdata bits at positions >= len SHALL remain 0.
REQ-025 A 6-bit down-counter SHALL track the remaining shifts; the transition SHIFT->DONE SHALL occur on the edge that ends cycle len-1, with no wrap.
REQ-026 DONE SHALL last one cycle with scan_done=1, then return to IDLE; a scan_start in IDLE the following cycle SHALL be accepted.
REQ-027 scan_abort=1 in SHIFT SHALL return to IDLE on the next edge, with no scan_done and scan_rdata holding the partial bits.
REQ-028 scan_abort SHALL have no effect in IDLE and in DONE.
REQ-029 If scan_abort and the final shift cycle coincide, abort SHALL win and scan_done SHALL not pulse.
REQ-030 ctu_tst_short_chain SHALL hold the latched select from acceptance until the next accepted start.
REQ-031 scan_si SHALL be 0 when not in SHIFT.
REQ-032 All outputs SHALL be registered or decoded from registered state only, with no input-to-output combinational path.

Reset
REQ-033 Asserting jbus_rst_l low SHALL immediately force IDLE, including mid-SHIFT.
REQ-034 While jbus_rst_l is low: global_shift_enable, ctu_tst_short_chain, scan_si, scan_busy, scan_done, scan_err, scan_rparity = 0; scan_rdata = 0; counter = 0.
REQ-035 After jbus_rst_l deasserts, the first scan_start SHALL be accepted on the first rising edge.

Configuration
REQ-036 Macro CTU_SCAN_PARITY_EN: when defined, scan_rparity SHALL be registered in DONE as XOR of scan_rdata[31:0] and hold until the next accepted start (cleared on acceptance); when undefined, scan_rparity SHALL be tied 0 and no parity logic built.

Verification
REQ-037 start, len=4, wdata=0x0000000A, short=1, so_0 = 1,0,1,1 -> si 0,1,0,1; se high for 4 cycles; done pulses the next cycle; rdata=0x0000000D; rparity=1 with macro defined, 0 without.
REQ-038 start, len=32, wdata=0xFFFFFFFF, so_0 constant 1, short=0 -> 32 shift cycles; rdata=0xFFFFFFFF; ctu_tst_short_chain=0.
REQ-039 start with len=0 -> err pulses for 1 cycle; se never asserts; busy stays 0.
REQ-040 len=8, abort asserted in shift cycle 3 -> IDLE next edge; se drops; no done; rdata holds bits 0..3 only.
REQ-041 jbus_rst_l low in shift cycle 5 of len=16 -> se/busy drop immediately; rdata=0; a new start after deassertion runs normally.
REQ-042 second start during SHIFT and start on the cycle after done -> first ignored, second accepted.
